// File: rtl/mem_word_bridge.sv
// Byte-serial load/store sequencer in front of the byte-wide memory block.
// Define MISALIGN_TRAP_EN to return an error for misaligned half/word requests.
module mem_word_bridge (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] addr,
    output logic [7:0]  data_in,
    input  logic [7:0]  data_out,
    output logic        memory_read_en,
    output logic        memory_write_en,
    input  logic        ready
);

    typedef enum logic [2:0] {
        IDLE,
        DUMMY_ISSUE,
        DUMMY_GAP,
        RD_ISSUE,
        RD_WAIT,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] rbuf;
    logic [31:0] mirror_addr;
    logic        mirror_valid;
    logic        mirror_unknown;

    logic [2:0]  idx_n;
    logic [2:0]  nbytes;
    logic [31:0] next_addr;
    logic [7:0]  next_wbyte;
    logic [31:0] rbuf_nxt;
    logic [31:0] load_val;
    logic        req_err;
    logic        need_dummy;

    always_comb begin
        idx_n = idx + 3'd1;
        case (r_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        next_addr  = r_addr + {29'd0, idx_n};
        next_wbyte = r_wdata[{idx_n[1:0], 3'b000} +: 8];
        rbuf_nxt   = rbuf;
        rbuf_nxt[{idx[1:0], 3'b000} +: 8] = data_out;
        case (r_size)
            2'd0:    load_val = {{24{r_signed & rbuf_nxt[7]}}, rbuf_nxt[7:0]};
            2'd1:    load_val = {{16{r_signed & rbuf_nxt[15]}}, rbuf_nxt[15:0]};
            default: load_val = rbuf_nxt;
        endcase
        req_err = (req_size == 2'd3);
`ifdef MISALIGN_TRAP_EN
        req_err = req_err
                | ((req_size == 2'd1) && req_addr[0])
                | ((req_size == 2'd2) && (req_addr[1:0] != 2'd0));
`else
        req_err = req_err;
`endif
        // memory drops a read to its last-read address; break the repeat
        need_dummy = mirror_unknown
                   | (mirror_valid && (req_addr == mirror_addr));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= 3'd0;
            r_size          <= 2'd0;
            r_signed        <= 1'b0;
            r_addr          <= 32'd0;
            r_wdata         <= 32'd0;
            rbuf            <= 32'd0;
            mirror_addr     <= 32'd0;
            mirror_valid    <= 1'b0;
            mirror_unknown  <= 1'b1;
            req_ready       <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'd0;
            resp_err        <= 1'b0;
            addr            <= 32'd0;
            data_in         <= 8'd0;
            memory_read_en  <= 1'b0;
            memory_write_en <= 1'b0;
        end else begin
            req_ready       <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'd0;
            resp_err        <= 1'b0;
            addr            <= 32'd0;
            data_in         <= 8'd0;
            memory_read_en  <= 1'b0;
            memory_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        idx      <= 3'd0;
                        rbuf     <= 32'd0;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_write) begin
                            state           <= WRITE;
                            memory_write_en <= 1'b1;
                            addr            <= req_addr;
                            data_in         <= req_wdata[7:0];
                            mirror_valid    <= 1'b0;
                        end else if (need_dummy) begin
                            state          <= DUMMY_ISSUE;
                            memory_read_en <= 1'b1;
                            addr           <= req_addr ^ 32'd1;
                            mirror_addr    <= req_addr ^ 32'd1;
                            mirror_valid   <= 1'b1;
                            mirror_unknown <= 1'b0;
                        end else begin
                            state          <= RD_ISSUE;
                            memory_read_en <= 1'b1;
                            addr           <= req_addr;
                            mirror_addr    <= req_addr;
                            mirror_valid   <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                DUMMY_ISSUE: state <= DUMMY_GAP;
                DUMMY_GAP: begin
                    state          <= RD_ISSUE;
                    memory_read_en <= 1'b1;
                    addr           <= r_addr;
                    mirror_addr    <= r_addr;
                    mirror_valid   <= 1'b1;
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    if (ready) begin
                        rbuf <= rbuf_nxt;
                        idx  <= idx_n;
                        if (idx_n == nbytes) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= load_val;
                        end else begin
                            state          <= RD_ISSUE;
                            memory_read_en <= 1'b1;
                            addr           <= next_addr;
                            mirror_addr    <= next_addr;
                            mirror_valid   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (idx_n == nbytes) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        idx             <= idx_n;
                        memory_write_en <= 1'b1;
                        addr            <= next_addr;
                        data_in         <= next_wbyte;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
